// File: rtl/fm_radio_pkg.sv
// Shared FM radio definitions: audio LPF taps (Q10), fixed-point dequantize and
// the audio filter state type.
package fm_radio_pkg;

  localparam int AUDIO_DATA_WIDTH = 32;
  localparam int AUDIO_NUM_TAPS   = 32;
  localparam int AUDIO_DECIMATION = 8;
  localparam int QUANT_BITS       = 10;

  typedef enum logic [1:0] {
    S_READ  = 2'd0,
    S_MAC   = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  localparam logic signed [AUDIO_DATA_WIDTH-1:0] AUDIO_LPF_COEFFS [AUDIO_NUM_TAPS] = '{
    -32'sd1,   -32'sd2,   -32'sd4,   -32'sd6,   -32'sd5,   32'sd0,    32'sd10,   32'sd22,
    32'sd30,   32'sd28,   32'sd12,   -32'sd15,  -32'sd40,  -32'sd48,  -32'sd22,  32'sd40,
    32'sd120,  32'sd190,  32'sd230,  32'sd230,  32'sd190,  32'sd120,  32'sd40,   -32'sd22,
    -32'sd48,  -32'sd40,  -32'sd15,  32'sd12,   32'sd28,   32'sd30,   32'sd22,   32'sd10
  };

  // Arithmetic shift drops the fractional bits of a full-width Q product.
  function automatic logic signed [2*AUDIO_DATA_WIDTH-1:0] DEQUANTIZE(
    input logic signed [2*AUDIO_DATA_WIDTH-1:0] value,
    input int unsigned                          shift = QUANT_BITS
  );
    return value >>> shift;
  endfunction

endpackage

// File: rtl/audio_lpf_decim.sv
// Mono audio low-pass FIR with integer decimation; a single multiplier is
// time-shared across all taps once per DECIMATION input samples.
module audio_lpf_decim #(
  parameter int DATA_WIDTH = fm_radio_pkg::AUDIO_DATA_WIDTH,
  parameter int NUM_TAPS   = fm_radio_pkg::AUDIO_NUM_TAPS,
  parameter int DECIMATION = fm_radio_pkg::AUDIO_DECIMATION,
  parameter int QUANT_BITS = fm_radio_pkg::QUANT_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  input  logic                  out_full,
  output logic                  out_wr_en
);
  import fm_radio_pkg::*;

  localparam int TAP_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int CNT_W = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;

  state_t state, state_next;

  logic signed [DATA_WIDTH-1:0]   x [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0]   acc, acc_next, coef;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic [TAP_W-1:0]               tap_cnt;
  logic [CNT_W-1:0]               sample_cnt;
  logic                           pop, last_tap, group_done;

  assign pop        = in_rd_en;
  assign last_tap   = (tap_cnt == TAP_W'(NUM_TAPS - 1));
  assign group_done = (sample_cnt == CNT_W'(DECIMATION - 1));

  assign coef     = DATA_WIDTH'(AUDIO_LPF_COEFFS[tap_cnt]);
  assign prod     = (2*DATA_WIDTH)'(x[tap_cnt]) * (2*DATA_WIDTH)'(coef);
  assign acc_next = acc + DATA_WIDTH'(DEQUANTIZE(prod, QUANT_BITS));

  always_ff @(posedge clk) begin
    if (reset) state <= S_READ;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_READ:  if (pop && group_done) state_next = S_MAC;
      S_MAC:   if (last_tap) state_next = S_WRITE;
      S_WRITE: if (!out_full) state_next = S_READ;
      default: state_next = S_READ;
    endcase
  end

  always_comb begin
    in_rd_en  = (state == S_READ) && !in_empty;
    out_wr_en = (state == S_WRITE) && !out_full;
  end

  // Sample history, tap sequencing and accumulation; dout is loaded with the
  // final sum so it is already stable on the first S_WRITE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      x          <= '{default: '0};
      acc        <= '0;
      dout       <= '0;
      tap_cnt    <= '0;
      sample_cnt <= '0;
    end else begin
      if (pop) begin
        for (int k = NUM_TAPS - 1; k > 0; k--) x[k] <= x[k-1];
        x[0] <= din;
        if (group_done) begin
          sample_cnt <= '0;
          acc        <= '0;
          tap_cnt    <= '0;
        end else begin
          sample_cnt <= sample_cnt + 1'b1;
        end
      end
      if (state == S_MAC) begin
        acc     <= acc_next;
        tap_cnt <= last_tap ? '0 : tap_cnt + 1'b1;
        if (last_tap) dout <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_audio_lpf_decim.sv
// Self-checking bench for audio_lpf_decim: directed scenarios with random data
// compared against a direct convolution model of the decimating FIR.
module tb_audio_lpf_decim;
  localparam int NT  = 32;
  localparam int DEC = 8;
  localparam int QB  = 10;

  logic        clk = 1'b0;
  logic        reset, in_empty, out_full, in_rd_en, out_wr_en;
  logic [31:0] din, dout;

  int C [NT] = '{-1, -2, -4, -6, -5, 0, 10, 22,
                 30, 28, 12, -15, -40, -48, -22, 40,
                 120, 190, 230, 230, 190, 120, 40, -22,
                 -48, -40, -15, 12, 28, 30, 22, 10};

  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;
  int     got[$];
  longint pop_cyc[$];
  longint wr_cyc[$];
  int     exp_q[$];
  bit     both_bad = 1'b0;

  audio_lpf_decim dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .in_empty  (in_empty),
    .in_rd_en  (in_rd_en),
    .dout      (dout),
    .out_full  (out_full),
    .out_wr_en (out_wr_en)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (in_rd_en) pop_cyc.push_back(cyc);
    if (out_wr_en) begin
      got.push_back(int'(dout));
      wr_cyc.push_back(cyc);
    end
    if (in_rd_en && out_wr_en) both_bad = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d (0x%08h) expected=%0d (0x%08h)", tag,
             $signed(obs), obs, $signed(expv), expv);
    end
  endtask

  // Each output is the FIR evaluated right after every DEC-th sample, with
  // zero history before the first sample and 32-bit wrapping accumulation.
  function automatic void model(input int s[$]);
    exp_q.delete();
    for (int i = DEC - 1; i < s.size(); i += DEC) begin
      int acc = 0;
      for (int k = 0; k < NT; k++) begin
        if (i - k >= 0) begin
          longint p = longint'(s[i-k]) * longint'(C[k]);
          acc += int'(p >>> QB);
        end
      end
      exp_q.push_back(acc);
    end
  endfunction

  task automatic clear_mon();
    got.delete();
    pop_cyc.delete();
    wr_cyc.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; in_empty = 1'b1; out_full = 1'b0; din = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    clear_mon();
  endtask

  task automatic feed(input int s[$], input int gap_pct);
    int idx = 0;
    int budget = 0;
    while (idx < s.size() && budget < 5000) begin
      @(posedge clk); #1;
      if ($urandom_range(99) < gap_pct) in_empty = 1'b1;
      else begin
        in_empty = 1'b0;
        din = s[idx];
      end
      #3;
      if (in_rd_en) idx++;
      budget++;
    end
    @(posedge clk); #1;
    in_empty = 1'b1;
    chk("feed_all_popped", idx, s.size());
  endtask

  task automatic wait_out(input string tag, input int n, input int budget);
    int c = 0;
    while (got.size() < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    repeat (3) @(posedge clk);
    chk(tag, got.size(), n);
  endtask

  task automatic cmp_outputs(input string tag);
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), (i < got.size()) ? got[i] : 32'hxxxxxxxx, exp_q[i]);
  endtask

  initial begin
    int  s[$];
    int  imp_exp[8];
    logic [31:0] held;
    bit  bp_bad;

    reset = 1'b1; in_empty = 1'b1; out_full = 1'b0; din = '0;
    repeat (3) @(posedge clk);
    do_reset();
    #2;
    chk("reset_dout", dout, 32'd0);
    chk("reset_wr_en", out_wr_en, 1'b0);
    chk("reset_rd_en", in_rd_en, 1'b0);

    // Impulse: each output picks one tap per group
    imp_exp = '{C[7], C[15], C[23], C[31], 0, 0, 0, 0};
    s.delete(); s.push_back(1024); repeat (63) s.push_back(0);
    feed(s, 0);
    wait_out("impulse_count", 8, 200);
    for (int i = 0; i < 8; i++)
      chk($sformatf("impulse[%0d]", i), (i < got.size()) ? got[i] : 32'hxxxxxxxx, imp_exp[i]);
    chk("latency", (pop_cyc.size() >= 8 && wr_cyc.size() >= 1) ? 32'(wr_cyc[0] - pop_cyc[7]) : 32'hffffffff, 32'd33);

    // DC
    do_reset();
    s.delete(); repeat (64) s.push_back(1024);
    model(s);
    feed(s, 0);
    wait_out("dc_count", 8, 200);
    cmp_outputs("dc");

    // Backpressure on the first output
    do_reset();
    s.delete(); repeat (64) s.push_back(int'($urandom));
    model(s);
    out_full = 1'b1;
    bp_bad = 1'b0;
    held = '0;
    fork
      feed(s, 0);
      begin
        int w = 0;
        do begin
          @(posedge clk); #2;
          w++;
        end while (pop_cyc.size() < 8 && w < 2000);
        repeat (32) @(posedge clk);
        #4 held = dout;
        for (int i = 0; i < 20; i++) begin
          if (i > 0) #4;
          if (in_rd_en !== 1'b0 || out_wr_en !== 1'b0 || dout !== held) bp_bad = 1'b1;
          @(posedge clk);
        end
        #1 out_full = 1'b0;
        #3 chk("bp_write_on_release", out_wr_en, 1'b1);
      end
    join
    chk("bp_hold_quiet", bp_bad, 1'b0);
    chk("bp_held_value", held, exp_q[0]);
    wait_out("bp_count", 8, 400);
    cmp_outputs("bp");

    // Starvation: random gaps on the input side
    do_reset();
    s.delete(); repeat (256) s.push_back(int'($urandom));
    model(s);
    feed(s, 50);
    wait_out("starve_count", 32, 400);
    cmp_outputs("starve");

    // Reset during the second group's MAC at tap 10
    do_reset();
    s.delete(); repeat (16) s.push_back(int'($urandom));
    model(s);
    feed(s, 0);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (80) @(posedge clk);
    chk("midmac_writes", got.size(), 1);
    chk("midmac_first", (got.size() > 0) ? got[0] : 32'hxxxxxxxx, exp_q[0]);
    clear_mon();
    s.delete(); s.push_back(1024); repeat (63) s.push_back(0);
    feed(s, 0);
    wait_out("post_reset_impulse_count", 8, 200);
    for (int i = 0; i < 8; i++)
      chk($sformatf("post_reset_impulse[%0d]", i), (i < got.size()) ? got[i] : 32'hxxxxxxxx, imp_exp[i]);

    // Overflow wrap with full-scale positive input
    do_reset();
    s.delete(); repeat (32) s.push_back(32'h7FFFFFFF);
    model(s);
    feed(s, 0);
    wait_out("wrap_count", 4, 200);
    cmp_outputs("wrap");

    chk("no_rd_wr_overlap", both_bad, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/audio_lpf_decim.md
Name: audio_lpf_decim

Overview:
- Mono audio low-pass FIR with integer decimation.
- Sits directly downstream of the demodulator output FIFO. It consumes demodulated 32-bit fixed-point samples and writes one filtered sample per DECIMATION inputs into an audio output FIFO.
- Uses one multiplier, time-multiplexed over NUM_TAPS cycles per output.
- Uses the same FIFO handshake as the demod stage: rd_en/empty on the input side, wr_en/full on the output side.

Parameters:
- DATA_WIDTH, 32, sample and coefficient width (signed, Q format).
- NUM_TAPS, 32, FIR length. Must be a multiple of DECIMATION.
- DECIMATION, 8, number of inputs consumed per output produced.
- QUANT_BITS, 10, fractional bits. Dequantize means arithmetic right shift by QUANT_BITS.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- din  in  DATA_WIDTH  head of the upstream FIFO. First-word-fall-through: valid whenever in_empty=0.
- in_empty  in  1  upstream FIFO empty.
- in_rd_en  out  1  pops the upstream FIFO this cycle.
- dout  out  DATA_WIDTH  filtered, decimated sample.
- out_full  in  1  downstream FIFO full.
- out_wr_en  out  1  downstream FIFO captures dout this cycle.

Behaviour:
- Interface (already decided): one clock, clk. Reset is the port named reset, synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: in_rd_en=0, out_wr_en=0, dout=0; shift register all 0; accumulator 0; sample_cnt=0; tap_cnt=0; state=S_READ.
- Shift register: x[0] holds the newest sample, x[NUM_TAPS-1] the oldest. On each pop, x[k]<=x[k-1] and x[0]<=din.
- in_rd_en is combinational: (state==S_READ) && !in_empty. A pop shifts din in and increments sample_cnt.
- S_READ:
  - When a pop occurs with sample_cnt==DECIMATION-1: sample_cnt<=0, acc<=0, tap_cnt<=0, go to S_MAC.
  - While in_empty=1: stay in S_READ, no pop, no state change.
- S_MAC: one tap per cycle.
  - acc <= acc + dequant(x[tap_cnt]*COEFF[tap_cnt]).
  - The product is full 2*DATA_WIDTH signed. It is arithmetically shifted right by QUANT_BITS, then truncated to DATA_WIDTH.
  - The accumulator is DATA_WIDTH and wraps on overflow (two's complement, no saturation).
  - After tap_cnt==NUM_TAPS-1: go to S_WRITE.
- S_WRITE:
  - out_wr_en is combinational: (state==S_WRITE) && !out_full. dout=acc, registered and stable throughout S_WRITE.
  - When out_wr_en=1: return to S_READ next cycle.
  - While out_full=1: hold state and dout, out_wr_en=0, no input pops. Backpressure stalls the pipeline and no sample is dropped.
- Latency: from the pop of the DECIMATION-th input to out_wr_en is NUM_TAPS+1 cycles, given out_full=0.
- Throughput: one output per at least DECIMATION+NUM_TAPS+1 cycles.
- Startup: the first outputs use zero history. There is no warm-up suppression; every DECIMATION inputs yields exactly one output from the first group on.
- Reset asserted in any state, including mid-MAC or stalled in S_WRITE: next cycle all state returns to reset values. The partial accumulation is discarded and never written.
- out_wr_en and in_rd_en are never both 1 in the same cycle.

Decomposition:
- Shared package fm_radio_pkg holds:
  - QUANT_BITS constant and a DEQUANTIZE function (arithmetic shift).
  - AUDIO_LPF_COEFFS: NUM_TAPS-entry signed DATA_WIDTH constant array, Q10, ordered tap 0..NUM_TAPS-1.
  - The state enum type (S_READ, S_MAC, S_WRITE).
- No sub-module; a single module is natural.
- Top-level integration instantiates fifo on each side, as in the demod stage. That wiring is outside this block.

Test Plan:
- Impulse: push din=1024 followed by 63 zeros, out_full=0 → 8 outputs, equal to COEFF[7], COEFF[15], COEFF[23], COEFF[31], then 0,0,0,0.
- DC: push 64 samples of 1024 → outputs 4..8 each equal the sum over k of DEQUANTIZE(1024*COEFF[k]). Outputs 1..3 are partial sums over taps 0..8n-1.
- Backpressure: hold out_full=1 for 20 cycles when the first output is ready → out_wr_en=0, dout stable, in_rd_en=0 throughout. A single write occurs on the cycle out_full drops; the output sequence is identical to an unstalled run.
- Starvation: toggle in_empty randomly (50%) over 256 samples → output stream is bit-identical to the no-gap run. Exactly 32 writes.
- Reset mid-MAC: assert reset for 1 cycle at tap_cnt=10 of the second output → no write for that group. After reset, an impulse test reproduces the first scenario exactly.
- Overflow wrap: feed din=0x7FFFFFFF for 32 samples → outputs match the wrapping 32-bit golden model, with no saturation.
